uart_rx_fifo: RTL and testbench

- Synthesisable, parametrised UART receiver for SoC-level and testbench use.
- Supersedes the behavioural print-only UART monitor.
- Adds configurable word length, parity mode, stop bits and bit timing, per-word parity and framing error flags, and a buffered valid/ready output FIFO with overrun detection.
- Sits between the pad-level `rx` line and a consumer: a log/console sink, or a register-file front end.

---
 rtl/uart_rx_fifo.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with a 2-flop synchroniser, configurable frame format and a
// valid/ready receive FIFO that carries per-word parity and framing flags.
module uart_rx_fifo #(
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          rx_en_i,
   input  logic                          rx_i,
   output logic [DATA_BITS-1:0]          data_o,
   output logic                          parity_err_o,
   output logic                          frame_err_o,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic                          overrun_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o,
   output logic                          busy_o
);

   localparam int CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int WORD_W = DATA_BITS + 2;

   localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic             ODD       = (PARITY_ODD != 0);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state;
   logic                 rx_meta, rx_s, rx_prev;
   logic [CNT_W-1:0]     clk_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr, ferr;

   logic                 fall, mid, tick, push, pop, full, wr_en;
   logic [WORD_W-1:0]    push_word;

   // NOTE: sequential state is always written with non-blocking assignments so
   // every flop samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign fall = rx_prev & ~rx_s;
   assign mid  = (clk_cnt == MID_CNT);
   assign tick = (clk_cnt == LAST_CNT);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         clk_cnt  <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         shreg    <= '0;
         perr     <= 1'b0;
         ferr     <= 1'b0;
      end else if (!rx_en_i) begin
         state   <= IDLE;
         clk_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               clk_cnt <= '0;
               if (fall) state <= START;
            end
            START: begin
               if (mid) begin
                  // From here on every sample lands one full bit period later.
                  clk_cnt  <= '0;
                  state    <= rx_s ? IDLE : DATA;
                  bit_cnt  <= '0;
                  stop_cnt <= 1'b0;
                  perr     <= 1'b0;
                  ferr     <= 1'b0;
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (tick) begin
                  clk_cnt <= '0;
                  shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + BIT_W'(1);
                  if (bit_cnt == LAST_BIT) state <= (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            PARITY: begin
               if (tick) begin
                  clk_cnt <= '0;
                  perr    <= (^shreg) ^ rx_s ^ ODD;
                  state   <= STOP;
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (tick) begin
                  clk_cnt  <= '0;
                  ferr     <= ferr | ~rx_s;
                  stop_cnt <= 1'b1;
                  // Leaving at mid-stop lets a back-to-back start edge be seen.
                  if (stop_cnt == LAST_STOP) state <= IDLE;
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy_o    = (state != IDLE);
   assign push      = rx_en_i && (state == STOP) && tick && (stop_cnt == LAST_STOP);
   assign push_word = {ferr | ~rx_s, perr, shreg};

   logic [WORD_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;

   assign valid_o = (count_o != '0);
   assign full    = (count_o == FULL_CNT);
   assign pop     = valid_o && ready_i;
   assign wr_en   = push && (!full || pop);

   // NOTE: the storage array has no reset; occupancy and pointers define what
   // is valid, so clearing the data itself would only cost reset fan-out.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr] <= push_word;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_o   <= '0;
         overrun_o <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, pop})
            2'b10:   count_o <= count_o + (PTR_W + 1)'(1);
            2'b01:   count_o <= count_o - (PTR_W + 1)'(1);
            default: count_o <= count_o;
         endcase
         overrun_o <= push && full && !pop;
      end
   end

   assign {frame_err_o, parity_err_o, data_o} = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three instances (8N1, 8E1, 7N2) driven by a
// table of frames, hand-written corner sequences and a random queue model.
module tb_uart_rx_fifo;

   localparam int CPB        = 16;
   // Two synchroniser stages, one detect cycle, half a bit, then 9 whole bits.
   localparam int PUSH_EDGE  = 3 + CPB / 2 + 9 * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       rx  [3];
   logic       rdy [3];
   logic [7:0] data_a, data_b;
   logic [6:0] data_c;
   logic [2:0] perr, ferr, valid, ovr, busy;
   logic [3:0] cnt_a, cnt_b, cnt_c;

   int checks = 0;
   int errors = 0;
   int ovr_n [3];
   int cnt_pre, cnt_post;

   always #5 clk = ~clk;

   uart_rx_fifo u_a (
      .clk_i(clk), .rst_i(rst), .rx_en_i(en), .rx_i(rx[0]), .data_o(data_a),
      .parity_err_o(perr[0]), .frame_err_o(ferr[0]), .valid_o(valid[0]),
      .ready_i(rdy[0]), .overrun_o(ovr[0]), .count_o(cnt_a), .busy_o(busy[0]));

   uart_rx_fifo #(.PARITY_EN(1), .PARITY_ODD(0)) u_b (
      .clk_i(clk), .rst_i(rst), .rx_en_i(en), .rx_i(rx[1]), .data_o(data_b),
      .parity_err_o(perr[1]), .frame_err_o(ferr[1]), .valid_o(valid[1]),
      .ready_i(rdy[1]), .overrun_o(ovr[1]), .count_o(cnt_b), .busy_o(busy[1]));

   uart_rx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) u_c (
      .clk_i(clk), .rst_i(rst), .rx_en_i(en), .rx_i(rx[2]), .data_o(data_c),
      .parity_err_o(perr[2]), .frame_err_o(ferr[2]), .valid_o(valid[2]),
      .ready_i(rdy[2]), .overrun_o(ovr[2]), .count_o(cnt_c), .busy_o(busy[2]));

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) if (ovr[i] === 1'b1) ovr_n[i]++;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [8:0] dat(input int u);
      case (u)
         0:       return {1'b0, data_a};
         1:       return {1'b0, data_b};
         default: return {2'b00, data_c};
      endcase
   endfunction

   function automatic int occ(input int u);
      case (u)
         0:       return int'(cnt_a);
         1:       return int'(cnt_b);
         default: return int'(cnt_c);
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one frame starting at a negedge; k counts posedges since the start bit.
   task automatic send(input int u, input logic [8:0] d, input bit pbit, input bit bad_last,
                       input int gap, input int pop_at, output int first_valid);
      bit bits[$];
      int nb = (u == 2) ? 7 : 8;
      int ns = (u == 2) ? 2 : 1;
      int k  = 0;
      first_valid = -1;
      bits.push_back(1'b0);
      for (int i = 0; i < nb; i++) bits.push_back(d[i]);
      if (u == 1) bits.push_back(pbit);
      for (int s = 0; s < ns; s++) bits.push_back(!(bad_last && s == ns - 1));
      foreach (bits[b]) begin
         rx[u] = bits[b];
         repeat (CPB) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (valid[u] && first_valid < 0) first_valid = k;
            if (pop_at >= 0 && k == pop_at - 1) begin
               cnt_pre = occ(u);
               rdy[u]  = 1'b1;
            end
            if (pop_at >= 0 && k == pop_at) begin
               cnt_post = occ(u);
               rdy[u]   = 1'b0;
            end
         end
      end
      rx[u] = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic drain_check(input int u, input logic [8:0] d, input bit pe, input bit fe,
                              input string name);
      int t = 0;
      while (!valid[u] && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!valid[u]) begin
         check({name, "_valid"}, 0, 1);
         return;
      end
      check({name, "_data"}, int'(dat(u)), int'(d));
      check({name, "_perr"}, int'(perr[u]), int'(pe));
      check({name, "_ferr"}, int'(ferr[u]), int'(fe));
      rdy[u] = 1'b1;
      @(negedge clk);
      rdy[u] = 1'b0;
   endtask

   typedef struct {
      int         unit;
      logic [8:0] data;
      bit         pbit;
      bit         bad_stop;
      logic [8:0] exp_data;
      bit         exp_perr;
      bit         exp_ferr;
   } vec_t;

   vec_t       vecs [9];
   int         fv, base, exp_ovr, n;
   logic [8:0] d;
   bit         bad, p;
   logic [10:0] q[$];
   logic [10:0] e;

   initial begin
      vecs[0] = '{0, 9'h055, 1'b0, 1'b0, 9'h055, 1'b0, 1'b0};
      vecs[1] = '{0, 9'h0A3, 1'b0, 1'b0, 9'h0A3, 1'b0, 1'b0};
      vecs[2] = '{0, 9'h00A, 1'b0, 1'b0, 9'h00A, 1'b0, 1'b0};
      vecs[3] = '{1, 9'h007, 1'b1, 1'b0, 9'h007, 1'b0, 1'b0};
      vecs[4] = '{1, 9'h007, 1'b0, 1'b0, 9'h007, 1'b1, 1'b0};
      vecs[5] = '{0, 9'h041, 1'b0, 1'b1, 9'h041, 1'b0, 1'b1};
      vecs[6] = '{0, 9'h042, 1'b0, 1'b0, 9'h042, 1'b0, 1'b0};
      vecs[7] = '{2, 9'h03F, 1'b0, 1'b0, 9'h03F, 1'b0, 1'b0};
      vecs[8] = '{2, 9'h015, 1'b0, 1'b1, 9'h015, 1'b0, 1'b1};

      for (int i = 0; i < 3; i++) begin
         rx[i]    = 1'b1;
         rdy[i]   = 1'b0;
         ovr_n[i] = 0;
      end
      rst = 1'b1;
      en  = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         check($sformatf("reset_valid_%0d", u), int'(valid[u]), 0);
         check($sformatf("reset_count_%0d", u), occ(u), 0);
         check($sformatf("reset_busy_%0d", u), int'(busy[u]), 0);
         check($sformatf("reset_overrun_%0d", u), int'(ovr[u]), 0);
      end

      // Basic, parity, framing and two-stop-bit frames.
      foreach (vecs[i]) begin
         send(vecs[i].unit, vecs[i].data, vecs[i].pbit, vecs[i].bad_stop, 20, -1, fv);
         if (i == 0) check("t1_valid_latency_ok", int'(fv >= 152 && fv <= 157), 1);
         drain_check(vecs[i].unit, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr,
                     $sformatf("vec%0d", i));
      end

      // Overrun: nine words into an eight-entry FIFO with no pops.
      base = ovr_n[0];
      for (int w = 0; w < 9; w++) begin
         send(0, 9'(w), 1'b0, 1'b0, 4, -1, fv);
         if (w == 7) check("t4_full_count", occ(0), 8);
         if (w == 7) check("t4_no_early_overrun", ovr_n[0] - base, 0);
      end
      check("t4_overrun_pulses", ovr_n[0] - base, 1);
      check("t4_count_after_drop", occ(0), 8);
      for (int w = 0; w < 8; w++) drain_check(0, 9'(w), 1'b0, 1'b0, $sformatf("t4_pop%0d", w));
      check("t4_empty", occ(0), 0);

      // Overrun avoided by a pop on the very edge of the ninth push.
      base = ovr_n[0];
      for (int w = 0; w < 8; w++) send(0, 9'(w), 1'b0, 1'b0, 4, -1, fv);
      send(0, 9'h008, 1'b0, 1'b0, 4, PUSH_EDGE, fv);
      check("t4b_count_before", cnt_pre, 8);
      check("t4b_count_after", cnt_post, 8);
      check("t4b_no_overrun", ovr_n[0] - base, 0);
      for (int w = 1; w < 9; w++) drain_check(0, 9'(w), 1'b0, 1'b0, $sformatf("t4b_pop%0d", w));

      // False start: five-cycle low glitch.
      rx[0] = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 5) rx[0] = 1'b1;
         if (k == 6) check("t5_glitch_busy", int'(busy[0]), 1);
         if (k == 16) check("t5_glitch_idle", int'(busy[0]), 0);
      end
      check("t5_glitch_no_push", occ(0), 0);

      // Receiver disabled mid-frame with one word already queued.
      send(0, 9'h011, 1'b0, 1'b0, 4, -1, fv);
      fork
         send(0, 9'h0C3, 1'b0, 1'b0, 4, -1, fv);
         begin
            repeat (60) @(negedge clk);
            en = 1'b0;
            repeat (20) @(negedge clk);
            check("t5_disable_idle", int'(busy[0]), 0);
         end
      join
      check("t5_disable_count", occ(0), 1);
      check("t5_disable_head", int'(dat(0)), 'h11);
      en = 1'b1;
      repeat (4) @(negedge clk);
      send(0, 9'h05A, 1'b0, 1'b0, 4, -1, fv);
      drain_check(0, 9'h011, 1'b0, 1'b0, "t5_kept");
      drain_check(0, 9'h05A, 1'b0, 1'b0, "t5_reenable");

      // Random frames against a queue model, including stop errors and overruns.
      for (int r = 0; r < 3; r++) begin
         n       = $urandom_range(3, 11);
         base    = ovr_n[0];
         exp_ovr = 0;
         q.delete();
         for (int j = 0; j < n; j++) begin
            d   = 9'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            send(0, d, 1'b0, bad, 4 + $urandom_range(0, 6), -1, fv);
            if (q.size() < 8) q.push_back({bad, 1'b0, d});
            else exp_ovr++;
         end
         check($sformatf("rnd%0d_count", r), occ(0), q.size());
         check($sformatf("rnd%0d_overruns", r), ovr_n[0] - base, exp_ovr);
         while (q.size() > 0) begin
            e = q.pop_front();
            drain_check(0, e[8:0], e[9], e[10], $sformatf("rnd%0d", r));
         end
      end

      // Random data and parity bits on the even-parity receiver.
      q.delete();
      for (int j = 0; j < 8; j++) begin
         d = 9'($urandom_range(0, 255));
         p = 1'($urandom_range(0, 1));
         send(1, d, p, 1'b0, 4, -1, fv);
         q.push_back({1'b0, 1'(($countones(d) + int'(p)) % 2), d});
      end
      while (q.size() > 0) begin
         e = q.pop_front();
         drain_check(1, e[8:0], e[9], e[10], "rnd_par");
      end

      // Reset with three words queued empties the FIFO on the next cycle.
      for (int w = 1; w <= 3; w++) send(2, 9'(w), 1'b0, 1'b0, 4, -1, fv);
      check("t6_queued", occ(2), 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_reset_valid", int'(valid[2]), 0);
      check("t6_reset_count", occ(2), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
